// File: rtl/signed_accum_ctrl_if.sv
// signed_accum_ctrl_if
//   Bundles the three handshake channels of the signed accumulator sequencer.
//   start_* : burst command (operand count, saturate/wrap select)
//   op_*    : signed operand stream
//   res_*   : final sum and sticky overflow flag
//   Modports: master = command/operand source and result consumer,
//             slave  = the accumulator sequencer.
interface signed_accum_ctrl_if #(
  parameter int W     = 4,
  parameter int CNT_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [CNT_W-1:0] start_count;
  logic             start_sat;

  logic             op_valid;
  logic             op_ready;
  logic [W-1:0]     op_data;

  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_sum;
  logic             res_overflow;

  modport master (
    output start_valid, start_count, start_sat,
    output op_valid, op_data,
    output res_ready,
    input  start_ready, op_ready, res_valid, res_sum, res_overflow
  );

  modport slave (
    input  start_valid, start_count, start_sat,
    input  op_valid, op_data,
    input  res_ready,
    output start_ready, op_ready, res_valid, res_sum, res_overflow
  );
endinterface

// File: rtl/signed_accum_ctrl.sv
// signed_accum_ctrl
//   Sums a burst of W-bit two's-complement operands through one shared adder.
//   A start command carries the operand count (0 legal) and wrap/saturate mode;
//   operands follow on a valid/ready stream; the sum and a sticky overflow flag
//   are offered on a valid/ready result channel.
//
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous, active-high reset
//     bus   - signed_accum_ctrl_if.slave (start_*, op_*, res_* channels)
//     busy  - high whenever the sequencer is not idle
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a start command; start_ready high
//   ACCUM | consuming operands; op_ready high; remaining counts down to 0
//   DONE  | result presented; res_valid high until res_ready
module signed_accum_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  signed_accum_ctrl_if.slave   bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

  state_t           state;
  logic [W-1:0]     acc;
  logic             ovf;
  logic [CNT_W-1:0] remaining;
  logic             sat;

  // Handshake outputs are flops updated together with state, so no input
  // can reach them combinationally.
  logic             start_ready_q;
  logic             op_ready_q;
  logic             res_valid_q;

  // Shared adder and overflow detect. Overflow occurs only when both
  // addends share a sign and the wrapped sum does not.
  logic [W-1:0]     sum_wrap;
  logic             step_ovf;
  logic [W-1:0]     acc_next;

  always_comb begin
    sum_wrap = acc + bus.op_data;
    step_ovf = (acc[W-1] == bus.op_data[W-1]) && (sum_wrap[W-1] != acc[W-1]);
    acc_next = sum_wrap;
    if (step_ovf && sat) begin
      // Clamp toward the operand's sign: a positive overflow can only come
      // from two non-negative addends, a negative one from two negatives.
      acc_next = bus.op_data[W-1] ? MOST_NEG : MOST_POS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      ovf           <= 1'b0;
      remaining     <= '0;
      sat           <= 1'b0;
      start_ready_q <= 1'b1;
      op_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            sat           <= bus.start_sat;
            acc           <= '0;
            ovf           <= 1'b0;
            remaining     <= bus.start_count;
            start_ready_q <= 1'b0;
            busy          <= 1'b1;
            if (bus.start_count == '0) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              state       <= ACCUM;
              op_ready_q  <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (bus.op_valid) begin
            acc       <= acc_next;
            ovf       <= ovf | step_ovf;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state       <= DONE;
              op_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            busy          <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          start_ready_q <= 1'b1;
          op_ready_q    <= 1'b0;
          res_valid_q   <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.op_ready     = op_ready_q;
  assign bus.res_valid    = res_valid_q;
  // acc and ovf only change in IDLE (on start) and ACCUM, so they are
  // stable for the whole DONE phase.
  assign bus.res_sum      = acc;
  assign bus.res_overflow = ovf;

endmodule

// File: tb/tb_signed_accum_ctrl.sv
module tb_signed_accum_ctrl;

  localparam int W     = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;

  signed_accum_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();

  signed_accum_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   burst[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model on plain integers: true sum, then range check.
  task automatic model_push(input bit sat);
    int   a;
    int   t;
    bit   ov;
    exp_t e;
    a  = 0;
    ov = 1'b0;
    foreach (burst[i]) begin
      t = a + burst[i];
      if (t > 7 || t < -8) begin
        ov = 1'b1;
        if (sat) t = (t > 7) ? 7 : -8;
        else     t = (t > 7) ? t - 16 : t + 16;
      end
      a = t;
    end
    e.sum = a[W-1:0];
    e.ovf = ov;
    exp_q.push_back(e);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_start(input int cnt, input bit sat);
    int n;
    bus.start_valid = 1'b1;
    bus.start_count = cnt[CNT_W-1:0];
    bus.start_sat   = sat;
    n = 0;
    while (!bus.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_ready_wait", bus.start_ready, 1);
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.start_count = $urandom_range(0, 15);
    chk("busy_after_start", busy, 1);
    chk("start_ready_after_start", bus.start_ready, 0);
  endtask

  task automatic send_op(input int v, input int gap);
    int n;
    bus.op_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.op_data = $urandom_range(0, 15);
      @(negedge clk);
    end
    bus.op_valid = 1'b1;
    bus.op_data  = v[W-1:0];
    n = 0;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("op_ready_wait", bus.op_ready, 1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_data  = $urandom_range(0, 15);
  endtask

  task automatic check_result(input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_wait", bus.res_valid, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_has_entry", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("res_sum", bus.res_sum, e.sum);
      chk("res_overflow", bus.res_overflow, e.ovf);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_res_valid", bus.res_valid, 1);
        chk("hold_res_sum", bus.res_sum, e.sum);
        chk("hold_res_overflow", bus.res_overflow, e.ovf);
        chk("hold_start_ready", bus.start_ready, 0);
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_after_hs", bus.res_valid, 0);
    chk("busy_after_hs", busy, 0);
    chk("start_ready_after_hs", bus.start_ready, 1);
  endtask

  task automatic run_burst(input bit sat, input int gap_max, input int hold);
    model_push(sat);
    send_start(burst.size(), sat);
    if (burst.size() == 0) begin
      chk("zero_len_res_valid", bus.res_valid, 1);
      chk("zero_len_op_ready", bus.op_ready, 0);
    end else begin
      chk("op_ready_after_start", bus.op_ready, 1);
      foreach (burst[i]) send_op(burst[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
      chk("res_latency", bus.res_valid, 1);
      chk("op_ready_in_done", bus.op_ready, 0);
    end
    check_result(hold);
  endtask

  initial begin
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.start_count = '0;
    bus.start_sat   = 1'b0;
    bus.op_valid    = 1'b0;
    bus.op_data     = '0;
    bus.res_ready   = 1'b0;

    @(negedge clk);
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_sum", bus.res_sum, 0);
    chk("rst_res_overflow", bus.res_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Wrap, no overflow
    burst = '{1, 2, 3};        run_burst(1'b0, 0, 0);
    // Wrap, overflow both directions
    burst = '{4, 7};           run_burst(1'b0, 0, 0);
    burst = '{-4, -7};         run_burst(1'b0, 0, 0);
    // Saturate
    burst = '{4, 7};           run_burst(1'b1, 0, 0);
    burst = '{7, 1, -1};       run_burst(1'b1, 0, 0);
    burst = '{-4, -4};         run_burst(1'b1, 0, 0);
    // Sticky overflow with an arithmetically correct wrapped result
    burst = '{7, 1, -1};       run_burst(1'b0, 0, 0);
    // Zero length
    burst = {};                run_burst(1'b0, 0, 0);
    // Maximum length with random gaps
    burst = {};
    for (int i = 0; i < 15; i++) burst.push_back(int'($urandom_range(0, 15)) - 8);
    run_burst(1'b0, 3, 0);
    burst = {};
    for (int i = 0; i < 6; i++) burst.push_back(int'($urandom_range(0, 15)) - 8);
    run_burst(1'b1, 4, 0);
    // Backpressure on the result
    burst = '{3, 3};           run_burst(1'b0, 0, 5);

    // start_valid during ACCUM must be ignored
    burst = '{2, -5};
    model_push(1'b0);
    send_start(2, 1'b0);
    bus.start_valid = 1'b1;
    bus.start_count = 4'd0;
    bus.start_sat   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("accum_start_ready", bus.start_ready, 0);
      chk("accum_op_ready", bus.op_ready, 1);
    end
    bus.start_valid = 1'b0;
    send_op(2, 1);
    send_op(-5, 2);
    chk("res_latency_ignored_start", bus.res_valid, 1);
    check_result(1);

    // Async reset mid-burst: no result, sequencer idle immediately
    send_start(3, 1'b0);
    send_op(5, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_op_ready", bus.op_ready, 0);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_start_ready", bus.start_ready, 1);
    chk("abort_res_sum", bus.res_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_res_valid", bus.res_valid, 0);
    burst = '{-3};             run_burst(1'b0, 0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
